// File: rtl/gol_pkg.sv
`default_nettype none
// ============================================================================
// Module      : gol_pkg
// Description : Shared Game-of-Life constants: neighbour bit indices and the
//               window generator state encoding.
// Revision    : 1.0 - initial release
// ============================================================================
package gol_pkg;

    localparam int NB_NW = 0;
    localparam int NB_N  = 1;
    localparam int NB_NE = 2;
    localparam int NB_W  = 3;
    localparam int NB_E  = 4;
    localparam int NB_SW = 5;
    localparam int NB_S  = 6;
    localparam int NB_SE = 7;

    typedef enum logic [1:0] {
        FILL   = 2'd0,
        STREAM = 2'd1,
        FLUSH  = 2'd2
    } gol_win_state_t;

endpackage
`default_nettype wire

// File: rtl/gol_line_shift.sv
`default_nettype none
// ============================================================================
// Module      : gol_line_shift
// Description : Two-row-plus-three-cell shift register with enable and async
//               clear; presents the 3x3 window taps of its post-edge contents.
// Revision    : 1.0 - initial release
// ============================================================================
module gol_line_shift
    import gol_pkg::*;
#(
    parameter int GRID_W = 64
) (
    input  logic       i_clk,
    input  logic       i_reset,
    input  logic       i_en,
    input  logic       i_din,
    output logic       o_centre,
    output logic [7:0] o_nb
);

    localparam int C_LEN = 2 * GRID_W + 3;

    logic [C_LEN-1:0] r_sr;
    logic [C_LEN-1:0] w_sr_next;

    // Taps read the value the register holds after this edge, so a window can
    // be captured on the same edge that shifts in its last cell.
    assign w_sr_next = i_en ? {r_sr[C_LEN-2:0], i_din} : r_sr;

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_sr <= '0;
        end else begin
            r_sr <= w_sr_next;
        end
    end

    assign o_centre    = w_sr_next[GRID_W+1];
    assign o_nb[NB_SE] = w_sr_next[0];
    assign o_nb[NB_S]  = w_sr_next[1];
    assign o_nb[NB_SW] = w_sr_next[2];
    assign o_nb[NB_E]  = w_sr_next[GRID_W];
    assign o_nb[NB_W]  = w_sr_next[GRID_W+2];
    assign o_nb[NB_NE] = w_sr_next[2*GRID_W];
    assign o_nb[NB_N]  = w_sr_next[2*GRID_W+1];
    assign o_nb[NB_NW] = w_sr_next[2*GRID_W+2];

endmodule
`default_nettype wire

// File: rtl/gol_window_gen.sv
`default_nettype none
// ============================================================================
// Module      : gol_window_gen
// Description : Raster-order streaming 3x3 neighbourhood generator with zero
//               padding. Optional GOL_WINDOW_COORD_EN adds o_x/o_y outputs.
// Revision    : 1.0 - initial release
// ============================================================================
module gol_window_gen
    import gol_pkg::*;
#(
    parameter int GRID_W = 64,
    parameter int GRID_H = 48
) (
    input  logic       i_clk,
    input  logic       i_reset,
    input  logic       i_valid,
    output logic       o_ready,
    input  logic       i_val,
    output logic       o_valid,
    input  logic       i_ready,
    output logic       o_val,
    output logic [7:0] o_neighbours
`ifdef GOL_WINDOW_COORD_EN
    ,
    output logic [$clog2(GRID_W)-1:0] o_x,
    output logic [$clog2(GRID_H)-1:0] o_y
`endif
);

    localparam int C_IN_W = $clog2(GRID_W * GRID_H);
    localparam int C_FL_W = $clog2(GRID_W + 2);
    localparam int C_X_W  = $clog2(GRID_W);
    localparam int C_Y_W  = $clog2(GRID_H);

    localparam logic [C_IN_W-1:0] C_IN_FILL_LAST = C_IN_W'(GRID_W);
    localparam logic [C_IN_W-1:0] C_IN_LAST      = C_IN_W'(GRID_W * GRID_H - 1);
    localparam logic [C_FL_W-1:0] C_FL_LAST      = C_FL_W'(GRID_W);
    localparam logic [C_X_W-1:0]  C_X_LAST       = C_X_W'(GRID_W - 1);
    localparam logic [C_Y_W-1:0]  C_Y_LAST       = C_Y_W'(GRID_H - 1);

    gol_win_state_t     r_state;
    gol_win_state_t     w_state_next;
    logic [C_IN_W-1:0]  r_in_cnt;
    logic [C_FL_W-1:0]  r_flush_cnt;
    logic [C_X_W-1:0]   r_out_x;
    logic [C_Y_W-1:0]   r_out_y;

    logic       w_out_free;
    logic       w_accept;
    logic       w_flush_step;
    logic       w_shift;
    logic       w_load;
    logic       w_din;
    logic       w_centre;
    logic [7:0] w_nb;
    logic [7:0] w_mask;

    assign w_out_free   = !o_valid || i_ready;
    assign w_accept     = i_valid && o_ready;
    assign w_flush_step = (r_state == FLUSH) && w_out_free;
    assign w_shift      = w_accept || w_flush_step;
    assign w_load       = ((r_state == STREAM) && w_accept) || w_flush_step;
    assign w_din        = (r_state == FLUSH) ? 1'b0 : i_val;

    gol_line_shift #(
        .GRID_W (GRID_W)
    ) u_line_shift (
        .i_clk    (i_clk),
        .i_reset  (i_reset),
        .i_en     (w_shift),
        .i_din    (w_din),
        .o_centre (w_centre),
        .o_nb     (w_nb)
    );

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_state <= FILL;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        o_ready      = 1'b0;
        case (r_state)
            FILL: begin
                o_ready = 1'b1;
                if (i_valid && (r_in_cnt == C_IN_FILL_LAST)) begin
                    w_state_next = STREAM;
                end
            end
            STREAM: begin
                o_ready = w_out_free;
                if (i_valid && w_out_free && (r_in_cnt == C_IN_LAST)) begin
                    w_state_next = FLUSH;
                end
            end
            FLUSH: begin
                if (w_out_free && (r_flush_cnt == C_FL_LAST)) begin
                    w_state_next = FILL;
                end
            end
            default: w_state_next = FILL;
        endcase
    end

    // The input counter wraps on the frame's last accept, so it is already
    // clear when FLUSH hands back to FILL.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_in_cnt    <= '0;
            r_flush_cnt <= '0;
        end else begin
            if (w_accept) begin
                r_in_cnt <= (r_in_cnt == C_IN_LAST) ? '0 : r_in_cnt + 1'b1;
            end
            if (w_flush_step) begin
                r_flush_cnt <= (r_flush_cnt == C_FL_LAST) ? '0 : r_flush_cnt + 1'b1;
            end
        end
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_out_x <= '0;
            r_out_y <= '0;
        end else if (w_load) begin
            if (r_out_x == C_X_LAST) begin
                r_out_x <= '0;
                r_out_y <= (r_out_y == C_Y_LAST) ? '0 : r_out_y + 1'b1;
            end else begin
                r_out_x <= r_out_x + 1'b1;
            end
        end
    end

    always_comb begin
        w_mask = 8'hFF;
        if (r_out_x == '0) begin
            w_mask[NB_NW] = 1'b0;
            w_mask[NB_W]  = 1'b0;
            w_mask[NB_SW] = 1'b0;
        end
        if (r_out_x == C_X_LAST) begin
            w_mask[NB_NE] = 1'b0;
            w_mask[NB_E]  = 1'b0;
            w_mask[NB_SE] = 1'b0;
        end
        if (r_out_y == '0) begin
            w_mask[NB_NW] = 1'b0;
            w_mask[NB_N]  = 1'b0;
            w_mask[NB_NE] = 1'b0;
        end
        if (r_out_y == C_Y_LAST) begin
            w_mask[NB_SW] = 1'b0;
            w_mask[NB_S]  = 1'b0;
            w_mask[NB_SE] = 1'b0;
        end
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            o_valid      <= 1'b0;
            o_val        <= 1'b0;
            o_neighbours <= '0;
        end else if (w_load) begin
            o_valid      <= 1'b1;
            o_val        <= w_centre;
            o_neighbours <= w_nb & w_mask;
        end else if (i_ready) begin
            o_valid      <= 1'b0;
        end
    end

`ifdef GOL_WINDOW_COORD_EN
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            o_x <= '0;
            o_y <= '0;
        end else if (w_load) begin
            o_x <= r_out_x;
            o_y <= r_out_y;
        end
    end
`endif

endmodule
`default_nettype wire

// File: tb/tb_gol_window_gen.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : tb_gol_window_gen
// Description : Self-checking bench for gol_window_gen (4x3 grid) against a
//               padded-grid neighbourhood model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_gol_window_gen;
    import gol_pkg::*;

    localparam int GW = 4;
    localparam int GH = 3;
    localparam int NC = GW * GH;

    logic       i_clk   = 1'b0;
    logic       i_reset = 1'b1;
    logic       i_valid = 1'b0;
    logic       i_val   = 1'b0;
    logic       i_ready = 1'b1;
    logic       o_ready;
    logic       o_valid;
    logic       o_val;
    logic [7:0] o_neighbours;
`ifdef GOL_WINDOW_COORD_EN
    logic [1:0] o_x;
    logic [1:0] o_y;
`endif

    int         n_checks = 0;
    int         n_fail   = 0;
    logic [8:0] exp_q[$];
    logic [8:0] win[NC];
    int         mon_idx  = 0;
    int         n_win    = 0;
    bit         rand_rdy = 1'b0;
    logic       ready_force = 1'b1;

    gol_window_gen #(
        .GRID_W (GW),
        .GRID_H (GH)
    ) dut (
        .i_clk        (i_clk),
        .i_reset      (i_reset),
        .i_valid      (i_valid),
        .o_ready      (o_ready),
        .i_val        (i_val),
        .o_valid      (o_valid),
        .i_ready      (i_ready),
        .o_val        (o_val),
        .o_neighbours (o_neighbours)
`ifdef GOL_WINDOW_COORD_EN
        ,
        .o_x          (o_x),
        .o_y          (o_y)
`endif
    );

    always #5 i_clk = ~i_clk;

    always @(posedge i_clk) begin
        #1;
        i_ready = rand_rdy ? ($urandom_range(0, 3) != 0) : ready_force;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_checks++;
        if (obs !== exp_v) begin
            n_fail++;
            $display("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp_v);
        end
    endtask

    // {centre, neighbours} for cell (x,y); cells outside the grid are dead.
    function automatic logic [8:0] model_win(input logic [NC-1:0] f, input int x, input int y);
        logic [7:0] nb;
        int         k;
        nb = '0;
        k  = 0;
        for (int dy = -1; dy <= 1; dy++) begin
            for (int dx = -1; dx <= 1; dx++) begin
                if (dx != 0 || dy != 0) begin
                    if (x + dx >= 0 && x + dx < GW && y + dy >= 0 && y + dy < GH)
                        nb[k] = f[(y + dy) * GW + x + dx];
                    k++;
                end
            end
        end
        return {f[y * GW + x], nb};
    endfunction

    task automatic push_frame(input logic [NC-1:0] f);
        for (int y = 0; y < GH; y++)
            for (int x = 0; x < GW; x++)
                exp_q.push_back(model_win(f, x, y));
    endtask

    task automatic drive_cells(input logic [NC-1:0] f, input int n, input int maxgap);
        int g;
        for (int k = 0; k < n; k++) begin
            i_valid = 1'b0;
            repeat ($urandom_range(0, maxgap)) begin
                @(posedge i_clk);
                #1;
            end
            i_valid = 1'b1;
            i_val   = f[k];
            g = 0;
            @(negedge i_clk);
            while (!o_ready && g < 200) begin
                @(negedge i_clk);
                g++;
            end
            if (g >= 200) check("accept_timeout", 32'(g), 0);
            @(posedge i_clk);
            #1;
        end
        i_valid = 1'b0;
    endtask

    task automatic wait_drain();
        int g = 0;
        while (exp_q.size() != 0 && g < 400) begin
            @(negedge i_clk);
            g++;
        end
        check("drain", 32'(exp_q.size()), 0);
        repeat (6) @(posedge i_clk);
        #1;
    endtask

    always @(negedge i_clk) begin
        if (!i_reset && o_valid && i_ready) begin
            n_win++;
            if (exp_q.size() == 0) begin
                check("extra_window_queue_len", 0, 1);
            end else begin
                check($sformatf("win_idx%0d", mon_idx), 32'({o_val, o_neighbours}), 32'(exp_q.pop_front()));
`ifdef GOL_WINDOW_COORD_EN
                check("coord_x", 32'(o_x), 32'(mon_idx % GW));
                check("coord_y", 32'(o_y), 32'(mon_idx / GW));
`endif
                win[mon_idx] = {o_val, o_neighbours};
                mon_idx = (mon_idx + 1) % NC;
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [NC-1:0] f;
        int            cnt;

        repeat (3) @(posedge i_clk);
        @(negedge i_clk);
        check("rst_valid", 32'(o_valid), 0);
        check("rst_val", 32'(o_val), 0);
        check("rst_nb", 32'(o_neighbours), 0);
        check("rst_ready", 32'(o_ready), 1);
        @(posedge i_clk);
        #1;
        i_reset = 1'b0;

        // All-zero frame, then count FLUSH cycles with o_ready low.
        f = '0;
        push_frame(f);
        drive_cells(f, NC, 0);
        cnt = 0;
        @(negedge i_clk);
        while (!o_ready && cnt < 50) begin
            cnt++;
            @(negedge i_clk);
        end
        check("flush_cycles", 32'(cnt), 5);
        wait_drain();

        // Single live cell at (1,1).
        f = 12'h020;
        push_frame(f);
        drive_cells(f, NC, 1);
        wait_drain();
        check("single_centre", 32'(win[5]), 32'h100);
        check("single_00", 32'(win[0]), 32'h080);
        check("single_22", 32'(win[10]), 32'h001);

        // All-ones frame.
        f = '1;
        push_frame(f);
        drive_cells(f, NC, 0);
        wait_drain();
        check("ones_00", 32'(win[0]), 32'h1D0);
        check("ones_10", 32'(win[1]), 32'h1F8);
        check("ones_11", 32'(win[5]), 32'h1FF);
        check("ones_32", 32'(win[11]), 32'h10B);

        // All-ones frame with a 3-cycle downstream stall.
        f = '1;
        push_frame(f);
        fork
            drive_cells(f, NC, 0);
            begin
                logic [8:0] snap;
                repeat (8) @(negedge i_clk);
                ready_force = 1'b0;
                @(negedge i_clk);
                snap = {o_val, o_neighbours};
                check("stall_valid", 32'(o_valid), 1);
                check("stall_ready0", 32'(o_ready), 0);
                for (int s = 0; s < 2; s++) begin
                    @(negedge i_clk);
                    check("stall_hold", 32'({o_val, o_neighbours}), 32'(snap));
                    check("stall_ready", 32'(o_ready), 0);
                end
                ready_force = 1'b1;
            end
        join
        wait_drain();
        check("bp_ones_00", 32'(win[0]), 32'h1D0);
        check("bp_ones_32", 32'(win[11]), 32'h10B);

        // Reset while input 7 is offered mid-STREAM.
        f = NC'($urandom);
        push_frame(f);
        drive_cells(f, 7, 0);
        i_valid = 1'b1;
        i_val   = f[7];
        i_reset = 1'b1;
        exp_q.delete();
        @(negedge i_clk);
        check("midrst_valid", 32'(o_valid), 0);
        check("midrst_nb", 32'(o_neighbours), 0);
        check("midrst_ready", 32'(o_ready), 1);
        @(posedge i_clk);
        #1;
        i_reset = 1'b0;
        i_valid = 1'b0;
        mon_idx = 0;
        n_win   = 0;
        f = '0;
        push_frame(f);
        drive_cells(f, NC, 0);
        wait_drain();
        check("midrst_win_count", 32'(n_win), 12);

        // Back-to-back: blinker then all-zero.
        n_win = 0;
        push_frame(12'h070);
        push_frame(12'h000);
        drive_cells(12'h070, NC, 0);
        drive_cells(12'h000, NC, 0);
        wait_drain();
        check("b2b_win_count", 32'(n_win), 24);
        for (int x = 0; x < GW; x++)
            check($sformatf("b2b_row0_n_x%0d", x), 32'(win[x][NB_N]), 0);

        // Random frames with random gaps and random downstream readiness.
        rand_rdy = 1'b1;
        for (int r = 0; r < 4; r++) begin
            f = NC'($urandom);
            push_frame(f);
            drive_cells(f, NC, 2);
        end
        wait_drain();
        rand_rdy = 1'b0;
        repeat (3) @(posedge i_clk);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
